// File: rtl/sme_pkg.sv
// Shared types and sizing for the SME feeder: FSM state encoding, character
// and index widths, and default buffer capacities.
package sme_pkg;
    localparam int CHAR_W      = 8;
    localparam int IDX_W       = 5;
    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_RESULT
    } state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: writes append at the current length (until the supplied
// limit), reads walk a sequential pointer from index 0.
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int DEPTH = STR_MAX_DEF,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  limit,
    input  logic              rd_en,
    output logic [CHAR_W-1:0] rd_data,
    output logic              full,
    output logic              rd_last
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [CHAR_W-1:0] mem_d [DEPTH];
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;

    assign full    = (len_q >= limit);
    assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign rd_last = (rd_ptr_q == (len_q - LEN_W'(1)));

    always_comb begin
        mem_d    = mem_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            len_d    = '0;
            rd_ptr_d = '0;
        end else begin
            // Writes past the limit are dropped; the caller flags overflow.
            if (wr_en && !full) begin
                mem_d[len_q[ADDR_W-1:0]] = wr_data;
                len_d = len_q + LEN_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            rd_ptr_q <= '0;
        end else begin
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/sme_feeder.sv
// Buffers host string/pattern items and streams them to the SME, then returns
// the match result. Define SME_FEEDER_TIMEOUT_EN to bound the result wait.
//
// state     | meaning
// ST_IDLE   | ready for first character of a new item
// ST_LOAD   | collecting remaining characters of the item
// ST_SEND   | streaming buffered characters to the SME
// ST_WAIT   | pattern sent, waiting for SME valid
// ST_RESULT | result presented to host until res_ready
module sme_feeder
    import sme_pkg::*;
#(
    parameter int STR_MAX     = STR_MAX_DEF,
    parameter int PAT_MAX     = PAT_MAX_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic              in_last,
    input  logic [CHAR_W-1:0] in_char,
    output logic [CHAR_W-1:0] chardata,
    output logic              isstring,
    output logic              ispattern,
    input  logic              valid,
    input  logic              match,
    input  logic [IDX_W-1:0]  match_index,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_match,
    output logic [IDX_W-1:0]  res_index,
    output logic              res_timeout,
    output logic              ovf,
    output logic              busy
);
    localparam int LEN_W = $clog2(STR_MAX + 1);
    localparam logic [LEN_W-1:0] STR_LIM = LEN_W'(STR_MAX);
    localparam logic [LEN_W-1:0] PAT_LIM = LEN_W'(min_int(PAT_MAX, STR_MAX));

    state_t            state_q, state_d;
    logic              kind_q, kind_d;
    logic [CHAR_W-1:0] chardata_q, chardata_d;
    logic              isstring_q, isstring_d;
    logic              ispattern_q, ispattern_d;
    logic              res_match_q, res_match_d;
    logic [IDX_W-1:0]  res_index_q, res_index_d;
    logic              ovf_q, ovf_d;

    logic              accept, item_kind;
    logic              buf_clr, buf_rd, buf_full, buf_rd_last;
    logic [LEN_W-1:0]  buf_limit;
    logic [CHAR_W-1:0] buf_rd_data;

`ifdef SME_FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_timeout_q, res_timeout_d;
`endif

    assign in_ready  = !reset && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign accept    = in_valid && in_ready;
    assign item_kind = (state_q == ST_IDLE) ? in_kind : kind_q;
    assign buf_limit = item_kind ? PAT_LIM : STR_LIM;

    sme_char_buf #(
        .DEPTH (STR_MAX),
        .LEN_W (LEN_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (accept),
        .wr_data (in_char),
        .limit   (buf_limit),
        .rd_en   (buf_rd),
        .rd_data (buf_rd_data),
        .full    (buf_full),
        .rd_last (buf_rd_last)
    );

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        chardata_d  = chardata_q;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        ovf_d       = ovf_q | (accept & buf_full);
        buf_clr     = 1'b0;
        buf_rd      = 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
        cnt_d         = cnt_q;
        res_timeout_d = res_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d  = in_kind;
                    state_d = in_last ? ST_SEND : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && in_last) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Strobes are registered, so the SME sees each character one cycle later.
                chardata_d  = buf_rd_data;
                isstring_d  = ~kind_q;
                ispattern_d = kind_q;
                buf_rd      = 1'b1;
                if (buf_rd_last) begin
                    buf_clr = 1'b1;
                    state_d = kind_q ? ST_WAIT : ST_IDLE;
`ifdef SME_FEEDER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (valid) begin
                    res_match_d = match;
                    res_index_d = match_index;
                    state_d     = ST_RESULT;
`ifdef SME_FEEDER_TIMEOUT_EN
                    res_timeout_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= 1'b0;
            chardata_q  <= '0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            chardata_q  <= chardata_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef SME_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign chardata  = chardata_q;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign res_valid = (state_q == ST_RESULT);
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != ST_IDLE);
endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 Parameter STR_MAX, default 32, max string characters buffered.
REQ-002 Parameter PAT_MAX, default 8, max pattern characters buffered.
REQ-003 Parameter TIMEOUT_CYC, default 1024, cycles to wait for SME valid.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 in_valid / in_ready  input / output  1 / 1  host character handshake; transfer when both high.
REQ-007 in_kind  input  1  0 = string item, 1 = pattern item; sampled on first character of item.
REQ-008 in_last  input  1  marks final character of item.
REQ-009 in_char  input  8  ASCII character.
REQ-010 chardata  output  8  character to SME.
REQ-011 isstring / ispattern  output  1 / 1  SME framing strobes.
REQ-012 valid, match  input  1 each  SME result strobe and result.
REQ-013 match_index  input  5  SME match position.
REQ-014 res_valid / res_ready  output / input  1 / 1  result handshake to host.
REQ-015 res_match, res_index, res_timeout  output  1, 5, 1  captured result.
REQ-016 ovf  output  1  sticky: item exceeded buffer capacity.
REQ-017 busy  output  1  high in any state but IDLE.

Function
REQ-018 FSM states IDLE, LOAD, SEND, WAIT, RESULT.
REQ-019 IDLE: in_ready=1; first accepted char latches in_kind, writes buffer[0], goes LOAD (or SEND if in_last).
REQ-020 LOAD: in_ready=1; each accepted char written at next address; in_last -> SEND next cycle.
REQ-021 Chars beyond STR_MAX (string) or PAT_MAX (pattern) accepted and discarded; ovf set.
REQ-022 SEND: one buffered char per cycle on chardata, index 0 first; isstring=1 (string) or ispattern=1 (pattern) on exactly those cycles, never both.
REQ-023 Length-N item occupies exactly N consecutive SEND cycles; strobes low on cycle N+1.
REQ-024 String item: SEND -> IDLE, no result produced; a new string replaces the old in the SME.
REQ-025 Pattern item: SEND -> WAIT; WAIT captures match/match_index on first cycle valid=1, goes RESULT.
REQ-026 valid seen outside WAIT is ignored.
REQ-027 RESULT: res_valid=1, outputs stable until res_ready=1; then IDLE next cycle.
REQ-028 in_ready=0 in SEND, WAIT, RESULT.
REQ-029 chardata holds last driven value when strobes low.
REQ-030 Pattern sent before any string is still transmitted; SME response forwarded unchanged.

Reset
REQ-031 reset forces IDLE, from any state, mid-item included; buffer contents discarded.
REQ-032 Reset values: in_ready=0 during reset, chardata=0, isstring=0, ispattern=0, res_valid=0, res_match=0, res_index=0, res_timeout=0, ovf=0, busy=0.
REQ-033 in_ready=1 first cycle after reset deasserts.

Configuration
REQ-034 Macro SME_FEEDER_TIMEOUT_EN defined: WAIT counter, width clog2(TIMEOUT_CYC)+1, clears on WAIT entry; at TIMEOUT_CYC cycles without valid -> RESULT with res_timeout=1, res_match=0, res_index=0.
REQ-035 Macro undefined: no counter; WAIT waits indefinitely; res_timeout tied 0.

Structure
REQ-036 Package sme_pkg holds the state enum, CHAR_W=8, IDX_W=5, and the STR_MAX/PAT_MAX defaults.
REQ-037 One sub-module sme_char_buf: single-port write / sequential read character buffer with length counter, instantiated once sized STR_MAX.

Verification
REQ-038 String "abcd" -> 4 cycles isstring=1, chardata 'a','b','c','d'; no res_valid.
REQ-039 String "abcd", pattern "bc", SME valid with match=1, index=1 -> res_valid, res_match=1, res_index=1, held while res_ready=0 for 5 cycles.
REQ-040 40-char string -> first 32 sent, ovf=1, 8 characters discarded.
REQ-041 Timeout enabled, TIMEOUT_CYC=16, no valid -> res_timeout=1 after 16 WAIT cycles.
REQ-042 Reset asserted on SEND cycle 2 of 4 -> strobes 0 next cycle, IDLE, in_ready=1 after release.
REQ-043 valid pulsed during LOAD -> ignored; later pattern result captured correctly.
